// File: rtl/bist_pkg.sv
// Shared types for the RAM BIST/repair block: FSM states and the March C- element table.
package bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ELEM,
        S_CHECK,
        S_DONE
    } state_t;

    localparam int unsigned NUM_ELEM = 6;

    // Op i of an element: is_rd[i] selects read vs write, inv[i] selects ~B vs B.
    typedef struct packed {
        logic       down;
        logic [1:0] nops;
        logic [1:0] is_rd;
        logic [1:0] inv;
    } elem_t;

    function automatic elem_t elem_info(input logic [2:0] e);
        case (e)
            3'd0:    elem_info = '{1'b0, 2'd1, 2'b00, 2'b00};
            3'd1:    elem_info = '{1'b0, 2'd2, 2'b01, 2'b10};
            3'd2:    elem_info = '{1'b0, 2'd2, 2'b01, 2'b01};
            3'd3:    elem_info = '{1'b1, 2'd2, 2'b01, 2'b10};
            3'd4:    elem_info = '{1'b1, 2'd2, 2'b01, 2'b01};
            3'd5:    elem_info = '{1'b0, 2'd1, 2'b01, 2'b00};
            default: elem_info = '0;
        endcase
    endfunction

endpackage

// File: rtl/repair_cam.sv
// Spare-word CAM: address tags with valid bits and per-entry data registers.
// One lookup port serves allocation and functional writes; a second serves reads.
module repair_cam #(
    parameter int unsigned SPARES = 2,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_hit,
    output logic              full,
    input  logic              alloc_en,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DATA_W-1:0] rd_data
);
    localparam int unsigned IDX_W = (SPARES > 1) ? $clog2(SPARES) : 1;

    logic [SPARES-1:0] valid;
    logic [ADDR_W-1:0] tag  [SPARES];
    logic [DATA_W-1:0] data [SPARES];
    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              free_found;

    always_comb begin
        lk_hit     = 1'b0;
        rd_hit     = 1'b0;
        lk_idx     = '0;
        free_idx   = '0;
        free_found = 1'b0;
        rd_data    = '0;
        for (int unsigned i = 0; i < SPARES; i++) begin
            if (valid[i] && tag[i] == lk_addr) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (valid[i] && tag[i] == rd_addr) begin
                rd_hit  = 1'b1;
                rd_data = data[i];
            end
            if (!valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign full = &valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            valid <= '0;
        else if (clear)
            valid <= '0;
        else if (alloc_en && !full)
            valid[free_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (alloc_en && !full)
            tag[free_idx] <= lk_addr;
        if (wr_en && lk_hit)
            data[lk_idx] <= wr_data;
    end

endmodule

// File: rtl/ram_bist_repair.sv
// March C- BIST with spare-word repair, sitting between user logic and a synchronous RAM.
// Define BIST_DIAG_EN to add first-miscompare capture outputs (diag_*).
module ram_bist_repair
    import bist_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SPARES    = 2,
    parameter int unsigned FAILCNT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic                         repair_ok,
    output logic [FAILCNT_W-1:0]         fail_cnt,
    output logic [$clog2(SPARES+1)-1:0]  spares_used,
    input  logic [ADDR_W-1:0]            f_rd_addr,
    input  logic [ADDR_W-1:0]            f_wr_addr,
    input  logic [DATA_W-1:0]            f_wr_data,
    input  logic                         f_wr_en,
    output logic [DATA_W-1:0]            f_rd_data,
    output logic [ADDR_W-1:0]            ram_rd_addr,
    output logic [ADDR_W-1:0]            ram_wr_addr,
    output logic [DATA_W-1:0]            ram_wr_data,
    output logic                         ram_wr_en,
    input  logic [DATA_W-1:0]            ram_rd_data
`ifdef BIST_DIAG_EN
    ,
    output logic [ADDR_W-1:0]            diag_addr,
    output logic [DATA_W-1:0]            diag_exp,
    output logic [DATA_W-1:0]            diag_got,
    output logic [2:0]                   diag_elem
`endif
);
    localparam int unsigned SU_W = $clog2(SPARES + 1);

    state_t            state;
    logic [2:0]        elem;
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic              overflow;

    elem_t             cur;
    elem_t             nxt_info;
    logic              op_rd;
    logic              last_op;
    logic              last_addr;
    logic              run_end;
    logic              miscmp;
    logic              start_ok;
    logic [DATA_W-1:0] pat;
    logic              nxt_op;
    logic [2:0]        nxt_elem;
    logic [ADDR_W-1:0] nxt_addr;

    logic              cam_hit;
    logic              cam_full;
    logic              cam_alloc;
    logic              cam_rd_hit;
    logic [DATA_W-1:0] cam_rd_data;
    logic              spare_hit_q;
    logic [DATA_W-1:0] spare_q;

    always_comb begin
        cur       = elem_info(elem);
        nxt_info  = elem_info(elem + 3'd1);
        op_rd     = cur.is_rd[op];
        pat       = cur.inv[op] ? '1 : '0;
        last_op   = ({1'b0, op} == cur.nops - 2'd1);
        last_addr = cur.down ? (addr == '0) : (addr == '1);
        run_end   = last_op && last_addr && (elem == 3'(NUM_ELEM - 1));
        nxt_op    = 1'b0;
        nxt_elem  = elem;
        nxt_addr  = addr;
        if (!last_op) begin
            nxt_op = 1'b1;
        end else if (last_addr) begin
            nxt_elem = elem + 3'd1;
            nxt_addr = nxt_info.down ? '1 : '0;
        end else begin
            nxt_addr = cur.down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
        end
    end

    assign miscmp    = (state == S_CHECK) && (ram_rd_data != pat);
    assign cam_alloc = miscmp && !cam_hit;
    assign start_ok  = start && (state == S_IDLE || state == S_DONE);

    repair_cam #(
        .SPARES (SPARES),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cam (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .lk_addr  (busy ? addr : f_wr_addr),
        .lk_hit   (cam_hit),
        .full     (cam_full),
        .alloc_en (cam_alloc),
        .wr_en    (f_wr_en && !busy),
        .wr_data  (f_wr_data),
        .rd_addr  (f_rd_addr),
        .rd_hit   (cam_rd_hit),
        .rd_data  (cam_rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            elem        <= '0;
            op          <= 1'b0;
            addr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            repair_ok   <= 1'b0;
            fail_cnt    <= '0;
            spares_used <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_INIT;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        repair_ok   <= 1'b0;
                        fail_cnt    <= '0;
                        spares_used <= '0;
                        overflow    <= 1'b0;
                    end
                end
                S_INIT: begin
                    state <= S_ELEM;
                    elem  <= '0;
                    op    <= 1'b0;
                    addr  <= '0;
                    busy  <= 1'b1;
                end
                S_ELEM, S_CHECK: begin
                    if (miscmp) begin
                        if (fail_cnt != '1)
                            fail_cnt <= fail_cnt + FAILCNT_W'(1);
                        if (cam_alloc) begin
                            if (cam_full)
                                overflow <= 1'b1;
                            else
                                spares_used <= spares_used + SU_W'(1);
                        end
                    end
                    if (state == S_ELEM && op_rd) begin
                        state <= S_CHECK;
                    end else if (run_end) begin
                        // Fold in the final compare, which lands on this same edge.
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= (fail_cnt == '0) && !miscmp;
                        repair_ok <= !(overflow || (cam_alloc && cam_full));
                    end else begin
                        state <= S_ELEM;
                        op    <= nxt_op;
                        elem  <= nxt_elem;
                        addr  <= nxt_addr;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BIST_DIAG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || state == S_INIT) begin
            diag_addr <= '0;
            diag_exp  <= '0;
            diag_got  <= '0;
            diag_elem <= '0;
        end else if (miscmp && fail_cnt == '0) begin
            diag_addr <= addr;
            diag_exp  <= pat;
            diag_got  <= ram_rd_data;
            diag_elem <= elem;
        end
    end
`endif

    // Spare data is sampled at read issue, so a same-cycle write returns the old word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spare_hit_q <= 1'b0;
            spare_q     <= '0;
        end else begin
            spare_hit_q <= cam_rd_hit;
            spare_q     <= cam_rd_data;
        end
    end

    always_comb begin
        if (busy) begin
            ram_rd_addr = addr;
            ram_wr_addr = addr;
            ram_wr_data = pat;
            ram_wr_en   = (state == S_ELEM) && !op_rd;
            f_rd_data   = '0;
        end else begin
            ram_rd_addr = f_rd_addr;
            ram_wr_addr = f_wr_addr;
            ram_wr_data = f_wr_data;
            ram_wr_en   = f_wr_en;
            f_rd_data   = spare_hit_q ? spare_q : ram_rd_data;
        end
    end

endmodule

// File: tb/tb_ram_bist_repair.sv
// Scoreboard bench for ram_bist_repair with a stuck-at-capable synchronous RAM model.
module tb_ram_bist_repair;
    localparam int unsigned AW  = 4;
    localparam int unsigned DW  = 8;
    localparam int unsigned SP  = 2;
    localparam int unsigned FW  = 8;
    localparam int unsigned SUW = $clog2(SP + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           busy, done, pass, repair_ok;
    logic [FW-1:0]  fail_cnt;
    logic [SUW-1:0] spares_used;
    logic [AW-1:0]  f_rd_addr = '0;
    logic [AW-1:0]  f_wr_addr = '0;
    logic [DW-1:0]  f_wr_data = '0;
    logic           f_wr_en = 1'b0;
    logic [DW-1:0]  f_rd_data;
    logic [AW-1:0]  ram_rd_addr, ram_wr_addr;
    logic [DW-1:0]  ram_wr_data;
    logic           ram_wr_en;
    logic [DW-1:0]  ram_rd_data;
`ifdef BIST_DIAG_EN
    logic [AW-1:0]  diag_addr;
    logic [DW-1:0]  diag_exp, diag_got;
    logic [2:0]     diag_elem;
`endif

    always #5 clk = ~clk;

    ram_bist_repair #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .SPARES    (SP),
        .FAILCNT_W (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .repair_ok   (repair_ok),
        .fail_cnt    (fail_cnt),
        .spares_used (spares_used),
        .f_rd_addr   (f_rd_addr),
        .f_wr_addr   (f_wr_addr),
        .f_wr_data   (f_wr_data),
        .f_wr_en     (f_wr_en),
        .f_rd_data   (f_rd_data),
        .ram_rd_addr (ram_rd_addr),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_data (ram_rd_data)
`ifdef BIST_DIAG_EN
        ,
        .diag_addr   (diag_addr),
        .diag_exp    (diag_exp),
        .diag_got    (diag_got),
        .diag_elem   (diag_elem)
`endif
    );

    // Synchronous RAM, read-before-write; stuck[] forces bits to 1 on read.
    logic [DW-1:0] mem   [2**AW];
    logic [DW-1:0] stuck [2**AW];

    always @(posedge clk) begin
        ram_rd_data <= mem[ram_rd_addr] | stuck[ram_rd_addr];
        if (ram_wr_en)
            mem[ram_wr_addr] <= ram_wr_data;
    end

    typedef struct {
        string       tag;
        int unsigned pass, rok, fcnt, su, bcyc, daddr, delem, dexp, dgot;
    } res_t;
    typedef struct {
        string       tag;
        int unsigned busy, done, pass, rok, fcnt, su;
    } stat_t;
    typedef struct {
        string       tag;
        int unsigned exp;
    } rd_exp_t;

    res_t    done_q [$];
    stat_t   stat_q [$];
    rd_exp_t rd_q   [$];

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic rd_req   = 1'b0;
    logic stat_req = 1'b0;
    logic tmo_req  = 1'b0;
    logic fin_req  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    initial begin : monitor
        rd_exp_t     re;
        res_t        rr;
        stat_t       ss;
        logic        rd_pend   = 1'b0;
        logic        done_prev = 1'b0;
        int unsigned bcyc      = 0;
        forever begin
            @(negedge clk);
            if (start)
                bcyc = 0;
            else if (busy)
                bcyc++;
            if (rd_pend) begin
                if (rd_q.size() == 0) begin
                    chk("rd_unexpected", rd_q.size(), 1);
                end else begin
                    re = rd_q.pop_front();
                    chk(re.tag, f_rd_data, re.exp);
                end
            end
            rd_pend = rd_req;
            if (stat_req && stat_q.size() != 0) begin
                ss = stat_q.pop_front();
                chk({ss.tag, ".busy"}, busy, ss.busy);
                chk({ss.tag, ".done"}, done, ss.done);
                chk({ss.tag, ".pass"}, pass, ss.pass);
                chk({ss.tag, ".repair_ok"}, repair_ok, ss.rok);
                chk({ss.tag, ".fail_cnt"}, fail_cnt, ss.fcnt);
                chk({ss.tag, ".spares_used"}, spares_used, ss.su);
            end
            if (done && !done_prev && done_q.size() != 0) begin
                rr = done_q.pop_front();
                chk({rr.tag, ".pass"}, pass, rr.pass);
                chk({rr.tag, ".repair_ok"}, repair_ok, rr.rok);
                chk({rr.tag, ".fail_cnt"}, fail_cnt, rr.fcnt);
                chk({rr.tag, ".spares_used"}, spares_used, rr.su);
                chk({rr.tag, ".busy_cycles"}, bcyc, rr.bcyc);
`ifdef BIST_DIAG_EN
                chk({rr.tag, ".diag_addr"}, diag_addr, rr.daddr);
                chk({rr.tag, ".diag_elem"}, diag_elem, rr.delem);
                chk({rr.tag, ".diag_exp"}, diag_exp, rr.dexp);
                chk({rr.tag, ".diag_got"}, diag_got, rr.dgot);
`endif
            end
            if (tmo_req) begin
                chk("done_timeout", done, 1);
                if (done_q.size() != 0)
                    void'(done_q.pop_front());
            end
            done_prev = done;
            if (fin_req) begin
                chk("rd_q_drained", rd_q.size(), 0);
                chk("done_q_drained", done_q.size(), 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic fwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk); #1 f_wr_en = 1'b1; f_wr_addr = a; f_wr_data = d;
        @(posedge clk); #1 f_wr_en = 1'b0;
    endtask

    task automatic fread(input logic [AW-1:0] a, input int unsigned exp, input string nm);
        @(posedge clk); #1 f_rd_addr = a; rd_req = 1'b1;
        rd_q.push_back('{nm, exp});
        @(posedge clk); #1 rd_req = 1'b0;
    endtask

    task automatic stat_check(input stat_t s);
        stat_q.push_back(s);
        stat_req = 1'b1;
        @(negedge clk); #1 stat_req = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) break;
        end
        if (!done) begin
            tmo_req = 1'b1;
            @(negedge clk); #1 tmo_req = 1'b0;
        end
    endtask

    task automatic run_bist(input res_t r, input bit busy_read);
        done_q.push_back(r);
        pulse_start();
        if (busy_read)
            fread(4'd3, 0, "busy_rd_zero");
        wait_done();
    endtask

    task automatic set_stuck(input int unsigned a0, input int unsigned a1, input int unsigned a2);
        for (int unsigned i = 0; i < 2**AW; i++)
            stuck[i] = '0;
        if (a0 < 2**AW) stuck[a0] = 8'h01;
        if (a1 < 2**AW) stuck[a1] = 8'h01;
        if (a2 < 2**AW) stuck[a2] = 8'h01;
    endtask

    initial begin : stimulus
        set_stuck(99, 99, 99);
        stat_check('{"reset", 0, 0, 0, 0, 0, 0});
        @(posedge clk); #1 rst = 1'b1;

        // Fault-free RAM.
        run_bist('{"clean", 1, 1, 0, 0, 240, 0, 0, 0, 0}, 1'b1);

        // Stuck-at-1 bit 0 at address 5: fails the three reads of B.
        set_stuck(5, 99, 99);
        run_bist('{"stuck5", 0, 1, 3, 1, 240, 5, 1, 8'h00, 8'h01}, 1'b0);
        fwrite(4'd5, 8'hA4);
        fread(4'd5, 8'hA4, "rep5_rd");
        fwrite(4'd6, 8'h5A);
        fread(4'd6, 8'h5A, "plain6_rd");

        // Write and read the repaired word in the same cycle, then read again.
        @(posedge clk); #1;
        f_wr_en = 1'b1; f_wr_addr = 4'd5; f_wr_data = 8'h3C;
        f_rd_addr = 4'd5; rd_req = 1'b1;
        rd_q.push_back('{"same_cyc_old", 8'hA4});
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        rd_q.push_back('{"next_cyc_new", 8'h3C});
        @(posedge clk); #1 rd_req = 1'b0;

        // Three faulty words, two spares: address 13 overflows.
        set_stuck(2, 9, 13);
        run_bist('{"overflow", 0, 0, 9, 2, 240, 2, 1, 8'h00, 8'h01}, 1'b0);
        fwrite(4'd13, 8'hA4);
        fread(4'd13, 8'hA5, "unrep13_rd");
        fwrite(4'd2, 8'h40);
        fread(4'd2, 8'h40, "rep2_rd");

        // Reset 100 cycles into a run (spares already allocated by then).
        pulse_start();
        repeat (100) @(posedge clk);
        #1 rst = 1'b0;
        stat_check('{"abort", 0, 0, 0, 0, 0, 0});
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        set_stuck(99, 99, 99);
        run_bist('{"after_abort", 1, 1, 0, 0, 240, 0, 0, 0, 0}, 1'b0);

        repeat (2) @(posedge clk);
        fin_req = 1'b1;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ram_bist_repair.md
Name: ram_bist_repair

Overview:
- Parametrised successor of the board-level RAM self-test wrapper.
- Runs March C- on an external synchronous RAM, using a word background and its inverse.
- Logs failing addresses into a small spare-word CAM, then transparently remaps functional accesses to repaired words.
- Sits between user logic and the RAM macro; status goes to top-level LEDs/registers.

Parameters:
- ADDR_W, 10, RAM address width; depth = 2**ADDR_W.
- DATA_W, 8, RAM word width.
- SPARES, 2, number of spare words (1..8).
- FAILCNT_W, 8, width of the saturating fail counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins test when idle.
- busy  out  1  test in progress.
- done  out  1  high from test end until next start.
- pass  out  1  valid with done; no compare errors.
- repair_ok  out  1  valid with done; every failing address holds a spare.
- fail_cnt  out  FAILCNT_W  saturating miscompare count.
- spares_used  out  $clog2(SPARES+1)  allocated spare entries.
- f_rd_addr, f_wr_addr  in  ADDR_W  functional addresses.
- f_wr_data  in  DATA_W  functional write data.
- f_wr_en  in  1  functional write enable.
- f_rd_data  out  DATA_W  functional read data, 1-cycle latency.
- ram_rd_addr, ram_wr_addr  out  ADDR_W  to RAM.
- ram_wr_data  out  DATA_W  to RAM.
- ram_wr_en  out  1  to RAM.
- ram_rd_data  in  DATA_W  from RAM, valid the cycle after ram_rd_addr.

Behaviour:
- Reset (rst low, async): FSM IDLE; busy=0, done=0, pass=0, repair_ok=0, fail_cnt=0, spares_used=0; all CAM entries invalid; ram_wr_en=0.
- FSM states: IDLE -> INIT -> ELEM -> CHECK -> DONE.
  - start in IDLE or DONE -> INIT: clears counters, CAM and done.
  - INIT: one cycle -> ELEM, element 0, address 0.
  - start while busy is ignored.
- March elements (B = {DATA_W{1'b0}}, ~B its inverse):
  - E0 up w B
  - E1 up r B, w ~B
  - E2 up r ~B, w B
  - E3 down r B, w ~B
  - E4 down r ~B, w B
  - E5 up r B
- Per address:
  - Read op: issue cycle, then compare cycle (CHECK) with ram_rd_data.
  - Write op: 1 cycle, ram_wr_en=1.
  - Element address wraps 2**ADDR_W-1 -> 0 (up) or 0 -> 2**ADDR_W-1 (down) into the next element.
  - Total cycles = 2**ADDR_W * 15.
- Miscompare:
  - fail_cnt increments, saturating at all-ones; pass cleared.
  - Address already in CAM: nothing further.
  - Free entry available: allocate it (lowest index) and increment spares_used.
  - CAM full: set sticky overflow.
- After E5: DONE, busy=0, done=1.
  - pass = (fail_cnt==0).
  - repair_ok = ~overflow.
- During busy: RAM ports driven by the BIST; functional writes dropped; f_rd_data=0.
- Functional mode (not busy):
  - RAM ports pass through from f_*.
  - f_wr_en to an address matching a valid CAM entry also loads that entry's data register, same cycle.
  - Read path: f_rd_addr is registered and compared against the CAM.
  - On a hit, f_rd_data = spare data; otherwise ram_rd_data.
  - Spare write in cycle N is visible to a read issued in cycle N+1.
- Simultaneous f_wr_en and f_rd to the same repaired address: read returns old spare data, matching RAM read-before-write.
- Reset mid-test: aborts immediately and clears the CAM; RAM contents undefined.
- Spare data registers are not reset; they are undefined until written.

Optional Feature:
- BIST_DIAG_EN defined: adds outputs diag_addr (ADDR_W), diag_exp (DATA_W), diag_got (DATA_W) and diag_elem (3).
  - These capture the first miscompare of a run.
  - Cleared to 0 at INIT; held until the next start.
- Undefined: ports and registers absent; other behaviour identical.

Decomposition:
- Package bist_pkg:
  - FSM state enum.
  - March element table: direction, op count, read/write polarity per op.
  - Constant NUM_ELEM=6.
- Sub-module repair_cam, parameters SPARES/ADDR_W/DATA_W:
  - valid/address/data arrays.
  - match lookup, allocate port, functional write port, hit index/data output.

Test Plan:
- Fault-free RAM model, ADDR_W=4: start -> busy for 240 cycles; done=1, pass=1, repair_ok=1, fail_cnt=0, spares_used=0.
- Stuck-at-1 on bit 0 at address 5 -> pass=0, repair_ok=1, spares_used=1, fail_cnt=3.
  - Then functional write 0xA4 to addr 5 and read back -> f_rd_data=0xA4.
- Stuck faults at addresses 2, 9 and 13 with SPARES=2 -> spares_used=2, repair_ok=0; address 13 not remapped.
- Assert rst low at cycle 100 of a test -> busy=0, done=0 immediately; a later start completes normally.
- Functional write 0x3C then read at the same repaired address in the same cycle -> old value; the next-cycle read returns 0x3C.
- BIST_DIAG_EN with the stuck-at-1 at address 5 -> diag_addr=5, diag_elem=1, diag_exp=0x00, diag_got=0x01.
